// File: rtl/pg_prng_pkg.sv
// Shared widths and types for the pg_prng multiply-accumulate generator.
package pg_prng_pkg;

   localparam int ACC_W    = 48;
   localparam int DEF_W0   = 18;
   localparam int DEF_W1   = 25;
   localparam int DEF_WOUT = 32;

   typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/pg_prng_mul.sv
// Unregistered unsigned W0 x W1 multiplier, kept plain so synthesis maps it onto one DSP48.
module pg_prng_mul #(
   parameter int W0 = 18,
   parameter int W1 = 25
) (
   input  logic [W0-1:0]    a,
   input  logic [W1-1:0]    b,
   output logic [W0+W1-1:0] p
);

   // Both operands widened to the full product width so no bits are lost.
   assign p = {{W1{1'b0}}, a} * {{W0{1'b0}}, b};

endmodule

// File: rtl/pg_prng.sv
// Free-running pseudo-random word generator: s0*s1 feeds back into the state and accumulates.
// Optional PG_PRNG_STEP_EN adds an 'en' input that gates each step.
module pg_prng
   import pg_prng_pkg::*;
#(
   parameter int W0    = DEF_W0,
   parameter int W1    = DEF_W1,
   parameter int Wout  = DEF_WOUT,
   parameter int Init0 = 2,
   parameter int Init1 = 1
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef PG_PRNG_STEP_EN
   input  logic            en,
`endif
   output logic [Wout-1:0] dout
);

   localparam logic [W0-1:0] INIT0 = W0'(Init0);
   localparam logic [W1-1:0] INIT1 = W1'(Init1);

   generate
      if (W0 > 18)      begin : g_bad_w0   $fatal(1, "pg_prng: W0 must be <= 18");   end
      if (W1 > 25)      begin : g_bad_w1   $fatal(1, "pg_prng: W1 must be <= 25");   end
      if (W0 > W1)      begin : g_bad_ord  $fatal(1, "pg_prng: W0 must be <= W1");   end
      if (Wout > ACC_W) begin : g_bad_wout $fatal(1, "pg_prng: Wout must be <= 48"); end
   endgenerate

   logic [W0-1:0]    s0;
   logic [W1-1:0]    s1;
   acc_t             acc;
   logic [W0+W1-1:0] p;
   acc_t             p_ext;
   logic             step;

`ifdef PG_PRNG_STEP_EN
   assign step = en;
`else
   assign step = 1'b1;
`endif

   pg_prng_mul #(
      .W0 (W0),
      .W1 (W1)
   ) u_mul (
      .a (s0),
      .b (s1),
      .p (p)
   );

   assign p_ext = {{(ACC_W-W0-W1){1'b0}}, p};

   // Forcing the new state odd keeps the product from ever collapsing to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0  <= INIT0;
         s1  <= INIT1;
         acc <= '0;
      end else if (step) begin
         s0  <= s1[W0-1:0] | W0'(1);
         s1  <= p[W1-1:0] | W1'(1);
         acc <= acc + p_ext;
      end
   end

   assign dout = acc[Wout-1:0];

endmodule

// File: tb/tb_pg_prng.sv
// Scoreboard bench for pg_prng: a software model pushes expected words, sampled outputs pop them.
// Builds with or without PG_PRNG_STEP_EN.
module tb_pg_prng;

   localparam int  W0    = 18;
   localparam int  W1    = 25;
   localparam int  WOUT  = 32;
   localparam int  LONG  = 20000;
   localparam logic [63:0] MASK48 = (64'd1 << 48) - 64'd1;
   localparam logic [63:0] MASKW0 = (64'd1 << W0) - 64'd1;
   localparam logic [63:0] MASKW1 = (64'd1 << W1) - 64'd1;
   localparam logic [63:0] MASKWO = (64'd1 << WOUT) - 64'd1;

   logic            clk;
   logic            rst_n;
   logic [WOUT-1:0] dout;
`ifdef PG_PRNG_STEP_EN
   logic            en;
`endif

   int checks;
   int errors;

   logic [63:0] ms0, ms1, macc;
   logic [63:0] expQ[$];

   pg_prng dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef PG_PRNG_STEP_EN
      .en    (en),
`endif
      .dout  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      ms0  = 64'd2;
      ms1  = 64'd1;
      macc = 64'd0;
   endtask

   task automatic modelStep();
      logic [63:0] p;
      p    = ms0 * ms1;
      macc = (macc + p) & MASK48;
      ms0  = (ms1 & MASKW0) | 64'd1;
      ms1  = (p & MASKW1) | 64'd1;
   endtask

   // Drive one edge; when doStep the model advances before its expectation is queued.
   task automatic applyStimulus(input bit doStep);
      if (doStep) modelStep();
      expQ.push_back(macc & MASKWO);
      @(posedge clk);
      #1;
   endtask

   task automatic popCompare(input string tag);
      logic [63:0] e;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_queue_empty"}, 64'd0, 64'd1);
      end else begin
         e = expQ.pop_front();
         checkOutput(tag, {32'd0, dout}, e);
      end
   endtask

   task automatic checkKnown(input logic [63:0] exp, input string tag);
      expQ.push_back(exp);
      modelStep();
      @(posedge clk);
      #1;
      popCompare(tag);
   endtask

   initial begin
      logic [WOUT-1:0] prev;
      int repeats;
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
`ifdef PG_PRNG_STEP_EN
      en      = 1'b1;
`endif
      modelReset();

      // Reset held across several edges
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0);
         popCompare("reset_hold");
      end

      @(negedge clk);
      rst_n = 1'b1;
      checkKnown(64'd2,   "seq1");
      checkKnown(64'd5,   "seq2");
      checkKnown(64'd14,  "seq3");
      checkKnown(64'd41,  "seq4");
      checkKnown(64'd284, "seq5");

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1);
         popCompare("seq_to10");
      end

      // Asynchronous reset between edges must clear dout at once
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", {32'd0, dout}, 64'd0);
      modelReset();
      expQ.delete();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0);
         popCompare("async_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;
      checkKnown(64'd2,   "restart1");
      checkKnown(64'd5,   "restart2");

`ifdef PG_PRNG_STEP_EN
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0);
         popCompare("en_hold");
      end
      @(negedge clk);
      en = 1'b1;
      checkKnown(64'd14, "en_resume1");
      checkKnown(64'd41, "en_resume2");
`endif

      // Long run: bit-exact against the model, including acc wrap at 2^48
      prev    = dout;
      repeats = 0;
      for (int i = 0; i < LONG; i++) begin
         applyStimulus(1'b1);
         popCompare("long_dout");
         checkOutput("long_acc", {16'd0, dut.acc}, macc);
         checkOutput("long_lsb", {62'd0, dut.s1[0], dut.s0[0]}, 64'd3);
         if (dout == prev) repeats++;
         prev = dout;
      end
      checkOutput("no_stuck", 64'(repeats), 64'd0);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
